gray_sequencer: RTL

GRAY_SEQUENCER -- requirements
Module: gray_sequencer

---
 rtl/gray_pkg.sv | 28 ++
 rtl/bin2gray.sv | 15 +
 rtl/gray_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sequencer: FSM state encoding,
// the binary-to-Gray conversion function and the dwell-counter sizing rule.
package gray_pkg;

    // Widest code the conversion function handles; WIDTH must not exceed it.
    localparam int unsigned GRAY_MAX_W = 32;

    // Sequencer is either waiting for a start or stepping through codes.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Reflected binary Gray code: each bit is the XOR of a binary bit and
    // its left neighbour, so successive indices differ in one code bit.
    function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(
        input logic [GRAY_MAX_W-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Dwell counter counts 0..DWELL-1; a single bit is kept even for DWELL=1
    // so the counter never collapses to a zero-width vector.
    function automatic int unsigned dwell_cnt_width(input int unsigned dwell);
        return (dwell <= 1) ? 1 : $clog2(dwell);
    endfunction

endpackage : gray_pkg

// File: rtl/bin2gray.sv
// Purely combinational binary-to-Gray converter, WIDTH bits wide.
module bin2gray
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    // Widen into the package function, then keep the low WIDTH bits; the
    // upper bits of the widened input are zero so they add nothing.
    assign o_gray = WIDTH'(bin_to_gray(GRAY_MAX_W'(i_bin)));

endmodule : bin2gray

// File: rtl/gray_sequencer.sv
// Gray-code sequencer: after start, walks the 2^WIDTH Gray codes in
// ascending or descending index order, holding each code for DWELL cycles.
// One-shot runs stop when the index wraps back to 0; continuous runs keep
// wrapping. stop aborts a run and freezes the current code.
module gray_sequencer
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DWELL = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] code,
    output logic [WIDTH-1:0] index,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      CNT_W     = dwell_cnt_width(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] INDEX_ONE = WIDTH'(1);

    // Architectural state.
    state_t           r_state;
    logic [WIDTH-1:0] r_index;
    logic [WIDTH-1:0] r_code;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_mode;
    logic             r_step;
    logic             r_busy;
    logic             r_done;

    // Next-code datapath.
    logic [WIDTH-1:0] w_next_index;
    logic [WIDTH-1:0] w_next_code;
    logic             w_dwell_end;
    logic             w_wrap;

    // Decide where the index goes next and whether the current dwell is over.
    always_comb begin
        w_dwell_end  = (r_cnt == CNT_LAST);
        w_next_index = r_dir ? (r_index - INDEX_ONE) : (r_index + INDEX_ONE);
        w_wrap       = (w_next_index == '0);
    end

    // The code for the next index is computed here and registered in the
    // same update as the index, so the two outputs can never disagree.
    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (w_next_index),
        .o_gray (w_next_code)
    );

    // Single-process FSM: state, counters and all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: reset is synchronous, so it lives inside the clocked
            // branch and clk alone appears in the sensitivity list.
            r_state <= ST_IDLE;
            r_index <= '0;
            r_code  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 1'b0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are raised only on
            // the edge that produces them, giving exactly one-cycle pulses.
            r_step <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // stop outranks start: both high means no run begins.
                    if (start && !stop) begin
                        r_dir   <= dir;
                        r_mode  <= mode;
                        r_index <= '0;
                        r_code  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        // Abort: code/index freeze where they are, no pulses.
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_dwell_end) begin
                        r_cnt   <= '0;
                        r_index <= w_next_index;
                        r_code  <= w_next_code;
                        r_step  <= 1'b1;
                        if (w_wrap) begin
                            r_done <= 1'b1;
                            // One-shot ends on the wrap edge with code 0 shown.
                            if (!r_mode) begin
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign code  = r_code;
    assign index = r_index;
    assign step  = r_step;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : gray_sequencer
